array_driver: RTL and testbench

ARRAY_DRIVER -- requirements
Module: array_driver

---
 rtl/array_pkg.sv | 19 +
 rtl/array_driver.sv | 130 +++++++++++++
 tb/tb_array_driver.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/array_pkg.sv
// Shared types for the array driver: lane count, array opcodes and driver FSM states.
package array_pkg;

    localparam int LANES = 5;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_SUB    = 2'd1,
        OP_MATMUL = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/array_driver.sv
// Sequences single commands through an external combinational array unit and
// optionally accumulates lane-wise results across a chain of commands.
module array_driver
    import array_pkg::*;
#(
    parameter int UNIT_SIZE = 32,
    parameter int TAG_W     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_op,
    input  logic                       i_cmd_acc,
    input  logic                       i_cmd_last,
    input  logic [LANES*UNIT_SIZE-1:0] i_cmd_a,
    input  logic [LANES*UNIT_SIZE-1:0] i_cmd_b,
    input  logic [TAG_W-1:0]           i_cmd_tag,
    output logic [1:0]                 o_arr_opcode,
    output logic [LANES*UNIT_SIZE-1:0] o_arr_in1,
    output logic [LANES*UNIT_SIZE-1:0] o_arr_in2,
    input  logic [LANES*UNIT_SIZE-1:0] i_arr_res,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [LANES*UNIT_SIZE-1:0] o_rsp_data,
    output logic [TAG_W-1:0]           o_rsp_tag,
    output logic                       o_rsp_err,
    output logic                       o_busy
);

    localparam int VEC_W = LANES * UNIT_SIZE;

    state_e             state, state_nxt;
    op_e                op_q;
    op_e                arr_op_q;
    logic               acc_q;
    logic               last_q;
    logic               chain_q;
    logic               err_q;
    logic [TAG_W-1:0]   tag_q;
    logic [VEC_W-1:0]   a_q;
    logic [VEC_W-1:0]   b_q;
    logic [VEC_W-1:0]   res_q;
    logic [VEC_W-1:0]   accum_q;
    logic               cmd_fire;

    // Lane-wise add; each lane wraps on its own, carries never cross lanes.
    function automatic logic [VEC_W-1:0] lane_add(input logic [VEC_W-1:0] x,
                                                   input logic [VEC_W-1:0] y);
        logic [VEC_W-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s[i*UNIT_SIZE +: UNIT_SIZE] = x[i*UNIT_SIZE +: UNIT_SIZE] + y[i*UNIT_SIZE +: UNIT_SIZE];
        end
        return s;
    endfunction

    assign cmd_fire     = i_cmd_valid && o_cmd_ready;
    assign o_cmd_ready  = (state == ST_IDLE);
    assign o_rsp_valid  = (state == ST_RESP);
    assign o_busy       = (state != ST_IDLE) || chain_q;
    assign o_arr_opcode = arr_op_q;
    assign o_arr_in1    = a_q;
    assign o_arr_in2    = b_q;
    assign o_rsp_data   = res_q;
    assign o_rsp_tag    = tag_q;
    assign o_rsp_err    = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_cmd_valid) state_nxt = ST_EXEC;
            // Intermediate chain members fold silently into the accumulator.
            ST_EXEC: state_nxt = (op_q != OP_RSVD && acc_q && !last_q) ? ST_IDLE : ST_RESP;
            ST_RESP: if (i_rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            arr_op_q <= OP_ADD;
            acc_q    <= 1'b0;
            last_q   <= 1'b0;
            chain_q  <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            accum_q  <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                op_q   <= op_e'(i_cmd_op);
                acc_q  <= i_cmd_acc;
                last_q <= i_cmd_last;
                tag_q  <= i_cmd_tag;
                // Reserved op leaves the array inputs untouched so they do not toggle.
                if (op_e'(i_cmd_op) != OP_RSVD) begin
                    arr_op_q <= op_e'(i_cmd_op);
                    a_q      <= i_cmd_a;
                    b_q      <= i_cmd_b;
                end
            end
            if (state == ST_EXEC) begin
                if (op_q == OP_RSVD) begin
                    res_q   <= '0;
                    err_q   <= 1'b1;
                    accum_q <= '0;
                    chain_q <= 1'b0;
                end else if (acc_q && !last_q) begin
                    accum_q <= lane_add(accum_q, i_arr_res);
                    chain_q <= 1'b1;
                end else if (acc_q) begin
                    res_q   <= lane_add(accum_q, i_arr_res);
                    err_q   <= 1'b0;
                    accum_q <= '0;
                    chain_q <= 1'b0;
                end else begin
                    res_q <= i_arr_res;
                    err_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_array_driver.sv
// Bench for array_driver paired with a behavioural lane-wise array unit;
// a scoreboard queue holds expected responses and a monitor checks them.
module tb_array_driver;
    import array_pkg::*;

    localparam int US = 32;
    localparam int TW = 4;
    localparam int VW = 5 * US;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_acc, cmd_last;
    logic [1:0]    cmd_op;
    logic [VW-1:0] cmd_a, cmd_b;
    logic [TW-1:0] cmd_tag;
    logic [1:0]    arr_opcode;
    logic [VW-1:0] arr_in1, arr_in2, arr_res;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [VW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;

    typedef struct {
        logic [VW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
        int            edge_n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic in_rsp = 1'b0;

    array_driver #(.UNIT_SIZE(US), .TAG_W(TW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_acc(cmd_acc), .i_cmd_last(cmd_last),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_tag(cmd_tag),
        .o_arr_opcode(arr_opcode), .o_arr_in1(arr_in1), .o_arr_in2(arr_in2),
        .i_arr_res(arr_res),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err),
        .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array unit: add, sub and (as a stand-in for matmul) lane product.
    always_comb begin
        arr_res = '0;
        for (int i = 0; i < 5; i++) begin
            case (arr_opcode)
                2'd0:    arr_res[i*US +: US] = arr_in1[i*US +: US] + arr_in2[i*US +: US];
                2'd1:    arr_res[i*US +: US] = arr_in1[i*US +: US] - arr_in2[i*US +: US];
                2'd2:    arr_res[i*US +: US] = arr_in1[i*US +: US] * arr_in2[i*US +: US];
                default: arr_res[i*US +: US] = '0;
            endcase
        end
    end

    function automatic logic [VW-1:0] lanes(input logic [31:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [VW-1:0] splat(input logic [31:0] v);
        return {v, v, v, v, v};
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic acc, input logic last,
                        input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [TW-1:0] tag,
                        input logic expect_rsp, input logic [VW-1:0] exp_data, input logic exp_err);
        bit   got;
        exp_t e;
        got = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_acc = acc; cmd_last = last;
        cmd_a = a; cmd_b = b; cmd_tag = tag;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=0 required=1");
        end else if (expect_rsp) begin
            e.data = exp_data; e.tag = tag; e.err = exp_err; e.edge_n = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sbq.size() == 0 && !rsp_valid) break;
            @(posedge clk); #1;
        end
        chk("drain_queue", VW'(sbq.size()), '0);
    endtask

    // Monitor: latency on first sight of a response, contents on its handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rsp_valid) begin
            if (!in_rsp) begin
                if (sbq.size() == 0) chk("unexpected_rsp", VW'(1), '0);
                else                 chk("rsp_latency", VW'(cyc), VW'(sbq[0].edge_n + 1));
            end
            in_rsp <= !rsp_ready;
            if (rsp_ready && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_tag", VW'(rsp_tag), VW'(e.tag));
                chk("rsp_err", VW'(rsp_err), VW'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_acc = 1'b0; cmd_last = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_cmd_ready", VW'(cmd_ready), VW'(1));
        chk("reset_rsp_valid", VW'(rsp_valid), '0);
        chk("reset_busy", VW'(busy), '0);
        chk("reset_rsp_err", VW'(rsp_err), '0);
        chk("reset_arr_opcode", VW'(arr_opcode), '0);
        chk("reset_arr_in1", arr_in1, '0);
        chk("reset_rsp_data", rsp_data, '0);

        // Plain add
        send(2'd0, 0, 0, lanes(1, 2, 3, 4, 5), lanes(10, 20, 30, 40, 50), 4'd3,
             1, lanes(11, 22, 33, 44, 55), 0);
        drain();
        chk("arr_in1_held", arr_in1, lanes(1, 2, 3, 4, 5));
        chk("arr_in2_held", arr_in2, lanes(10, 20, 30, 40, 50));

        // Sub with lane-0 underflow, then add with wrap in every lane
        send(2'd1, 0, 0, lanes(0, 100, 200, 300, 400), lanes(1, 7, 7, 7, 7), 4'd4,
             1, lanes(32'hFFFF_FFFF, 93, 193, 293, 393), 0);
        send(2'd0, 0, 0, splat(32'hFFFF_FFFF), lanes(1, 2, 3, 4, 5), 4'd6,
             1, lanes(0, 1, 2, 3, 4), 0);
        drain();

        // Three-member accumulate chain
        send(2'd0, 1, 0, splat(1), splat(0), 4'd7, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1 chk("chain_busy", VW'(busy), VW'(1));
        chk("chain_no_rsp", VW'(rsp_valid), '0);
        send(2'd0, 1, 0, splat(1), splat(0), 4'd7, 0, '0, 0);
        send(2'd0, 1, 1, splat(1), splat(0), 4'd8, 1, splat(3), 0);
        drain();
        chk("chain_done_busy", VW'(busy), '0);

        // Non-accumulating command in the middle of a chain
        send(2'd0, 1, 0, splat(1), splat(0), 4'd1, 0, '0, 0);
        send(2'd0, 0, 0, splat(3), splat(4), 4'd5, 1, splat(7), 0);
        send(2'd0, 1, 1, splat(1), splat(0), 4'd2, 1, splat(2), 0);
        drain();

        // Reserved op mid-chain clears the chain
        send(2'd1, 1, 0, splat(8), splat(3), 4'd9, 0, '0, 0);
        send(2'd3, 1, 0, splat(99), splat(99), 4'd9, 1, '0, 1);
        drain();
        chk("rsvd_opcode_held", VW'(arr_opcode), VW'(1));
        chk("rsvd_in1_held", arr_in1, splat(8));
        chk("rsvd_busy", VW'(busy), '0);
        send(2'd0, 1, 0, splat(2), splat(0), 4'd10, 0, '0, 0);
        send(2'd0, 1, 1, splat(3), splat(0), 4'd10, 1, splat(5), 0);
        drain();

        // Response back-pressure
        rsp_ready = 1'b0;
        send(2'd2, 0, 0, lanes(2, 3, 4, 5, 6), splat(7), 4'd12, 1, lanes(14, 21, 28, 35, 42), 0);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        chk("stall_rsp_seen", VW'(got), VW'(1));
        for (int k = 0; k < 5; k++) begin
            chk("stall_data", rsp_data, lanes(14, 21, 28, 35, 42));
            chk("stall_tag", VW'(rsp_tag), VW'(12));
            chk("stall_cmd_ready", VW'(cmd_ready), '0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_ready_after", VW'(cmd_ready), VW'(1));
        chk("stall_valid_after", VW'(rsp_valid), '0);

        // Reset while a command is in EXEC
        send(2'd1, 1, 0, splat(9), splat(4), 4'd11, 0, '0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_exec_valid", VW'(rsp_valid), '0);
        chk("rst_exec_busy", VW'(busy), '0);
        chk("rst_exec_ready", VW'(cmd_ready), VW'(1));
        chk("rst_exec_opcode", VW'(arr_opcode), '0);
        repeat (3) @(posedge clk);
        #1 chk("rst_exec_no_rsp", VW'(rsp_valid), '0);
        send(2'd0, 0, 0, splat(100), lanes(1, 2, 3, 4, 5), 4'd1, 1, lanes(101, 102, 103, 104, 105), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
